bcd_converter_n: RTL

BCD_CONVERTER_N -- requirements
Module: bcd_converter_n

---
 rtl/bcd_converter_n.sv | 130 +++++++++++++
 1 files changed

// File: rtl/bcd_converter_n.sv
// Sequential binary-to-BCD converter using one double-dabble step per clock, with valid/ready handshakes on both sides.
// Optional leading-zero mask enabled by defining BCD_BLANK_EN; otherwise blank is tied low.
module bcd_converter_n #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      bin_value,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   bcd_digits,
    output logic                  ovf,
    output logic [DIGITS-1:0]     blank
);

    // state | meaning
    // IDLE  | waiting for in_valid, last result held on outputs
    // SHIFT | one add-3/shift step per cycle, WIDTH cycles
    // DONE  | result presented until out_ready
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam int CW = $clog2(WIDTH + 1);
    localparam int BW = 4 * DIGITS;

    state_t          state_q, state_d;
    logic [BW-1:0]   dig_q, adj, dig_step;
    logic [WIDTH-1:0] bin_q;
    logic [CW-1:0]   cnt_q;
    logic            ovf_q, carry_out, last_shift;
    logic [BW-1:0]   res_digits;
    logic            res_ovf;

    always_comb begin
        adj = dig_q;
        for (int k = 0; k < DIGITS; k++) begin
            if (dig_q[4*k +: 4] >= 4'd5)
                adj[4*k +: 4] = dig_q[4*k +: 4] + 4'd3;
        end
        dig_step  = {adj[BW-2:0], bin_q[WIDTH-1]};
        carry_out = adj[BW-1];
        last_shift = (cnt_q == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = SHIFT;
            end
            SHIFT: if (last_shift) state_d = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Working registers change only in IDLE (capture) and SHIFT; results load on the final step.
    always_ff @(posedge clk) begin
        if (rst) begin
            dig_q      <= '0;
            bin_q      <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            res_digits <= '0;
            res_ovf    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    bin_q <= bin_value;
                    dig_q <= '0;
                    cnt_q <= '0;
                    ovf_q <= 1'b0;
                end
                SHIFT: begin
                    dig_q <= dig_step;
                    bin_q <= bin_q << 1;
                    cnt_q <= cnt_q + CW'(1);
                    ovf_q <= ovf_q | carry_out;
                    if (last_shift) begin
                        res_digits <= dig_step;
                        res_ovf    <= ovf_q | carry_out;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bcd_digits = res_digits;
    assign ovf        = res_ovf;

`ifdef BCD_BLANK_EN
    logic [DIGITS-1:0] blank_d, blank_q;
    logic              zero_run;

    always_comb begin
        blank_d  = '0;
        zero_run = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            zero_run   = zero_run & (dig_step[4*k +: 4] == 4'd0);
            blank_d[k] = zero_run;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            blank_q <= '0;
        else if (state_q == SHIFT && last_shift)
            blank_q <= blank_d;
    end

    assign blank = blank_q;
`else
    assign blank = '0;
`endif

endmodule
